// File: rtl/dual_issue_queue.sv
// dual_issue_queue
//   Instruction buffer and pairing stage between fetch and issue. Up to two
//   fetched instructions per cycle enter a circular queue. The two oldest
//   entries are decoded and checked for pairing hazards. One or two
//   instructions are then presented to issue under a valid/yumi handshake.
//
// Ports
//   clk_i              core clock
//   reset_n_i          asynchronous active-low reset
//   flush_i            discard every queued entry (redirect / mispredict)
//   dual_en_i          0 forces single issue
//   enq_count_i        instructions offered this cycle (0..2; 3 is illegal)
//   enq_instr_i        offered pair, [0] is the older one
//   enq_ready_o        at least two free entries
//   issue_v_o          a bundle is presented
//   issue_dual_o       the bundle holds two instructions
//   issue_instr_o      instruction for the integer pipe
//   issue_instr_f_o    instruction for the FP pipe
//   issue_decode_o     merged control of the presented bundle
//   issue_fp_decode_o  FP control of the presented bundle
//   issue_yumi_i       consumer takes the presented bundle
//   dual_count_o       saturating count of accepted dual bundles

package dual_issue_queue_pkg;

  typedef struct packed {
    logic read_rs1;
    logic read_rs2;
    logic write_rd;
    logic read_rs1_f;   // FP op reading an integer source (fmv.w.x, fcvt.s.w)
    logic write_rd_f;   // FP op writing an integer result (fmv.x.w, fcvt.w.s, compares)
    logic read_frs1;
    logic read_frs2;
    logic read_frs3;
    logic read_frs2_s;  // FP store data
    logic write_frd;
    logic write_frd_l;  // FP load result
    logic is_fp_op;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
  } decode_s;

  typedef struct packed {
    logic [4:0] fp_funct5;
    logic [2:0] fp_rm;
    logic       is_fma;
    logic [1:0] fma_op;
  } fp_decode_s;

endpackage

module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int els_p           = 8,
  parameter int counter_width_p = 32,
  localparam int lg_els_lp      = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       dual_en_i,
  input  logic [1:0]                 enq_count_i,
  input  logic [1:0][31:0]           enq_instr_i,
  output logic                       enq_ready_o,
  output logic                       issue_v_o,
  output logic                       issue_dual_o,
  output logic [31:0]                issue_instr_o,
  output logic [31:0]                issue_instr_f_o,
  output decode_s                    issue_decode_o,
  output fp_decode_s                 issue_fp_decode_o,
  input  logic                       issue_yumi_i,
  output logic [counter_width_p-1:0] dual_count_o
);

  function automatic decode_s cl_decode(input logic [31:0] instr);
    decode_s d;
    d = '0;
    case (instr[6:0])
      7'b0110011: begin d.read_rs1 = 1'b1; d.read_rs2 = 1'b1; d.write_rd = 1'b1; end
      7'b0010011: begin d.read_rs1 = 1'b1; d.write_rd = 1'b1; end
      7'b0000011: begin d.read_rs1 = 1'b1; d.write_rd = 1'b1; d.is_load = 1'b1; end
      7'b0110111,
      7'b0010111: d.write_rd = 1'b1;
      7'b0100011: begin d.read_rs1 = 1'b1; d.read_rs2 = 1'b1; d.is_store = 1'b1; end
      7'b1100011: begin d.read_rs1 = 1'b1; d.read_rs2 = 1'b1; d.is_branch = 1'b1; end
      7'b1101111: begin d.write_rd = 1'b1; d.is_jal = 1'b1; end
      7'b1100111: begin d.read_rs1 = 1'b1; d.write_rd = 1'b1; d.is_jalr = 1'b1; end
      // FP loads/stores run down the integer pipe (address generation)
      7'b0000111: begin d.read_rs1 = 1'b1; d.write_frd_l = 1'b1; d.is_load = 1'b1; end
      7'b0100111: begin d.read_rs1 = 1'b1; d.read_frs2_s = 1'b1; d.is_store = 1'b1; end
      7'b1010011: begin
        d.is_fp_op = 1'b1;
        case (instr[31:27])
          5'b11100,
          5'b11000: begin d.read_frs1 = 1'b1; d.write_rd_f = 1'b1; end
          5'b10100: begin d.read_frs1 = 1'b1; d.read_frs2 = 1'b1; d.write_rd_f = 1'b1; end
          5'b11110,
          5'b11010: begin d.read_rs1_f = 1'b1; d.write_frd = 1'b1; end
          5'b01011: begin d.read_frs1 = 1'b1; d.write_frd = 1'b1; end
          default:  begin d.read_frs1 = 1'b1; d.read_frs2 = 1'b1; d.write_frd = 1'b1; end
        endcase
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        d.is_fp_op  = 1'b1;
        d.read_frs1 = 1'b1;
        d.read_frs2 = 1'b1;
        d.read_frs3 = 1'b1;
        d.write_frd = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic fp_decode_s cl_fp_decode(input logic [31:0] instr);
    fp_decode_s f;
    f = '0;
    if (instr[6:0] == 7'b1010011) begin
      f.fp_funct5 = instr[31:27];
      f.fp_rm     = instr[14:12];
    end else if (instr[6:4] == 3'b100 && instr[1:0] == 2'b11) begin
      f.fp_rm  = instr[14:12];
      f.is_fma = 1'b1;
      f.fma_op = instr[3:2];
    end
    return f;
  endfunction

  logic [31:0]          r_mem [els_p];
  logic [lg_els_lp-1:0] r_rptr;
  logic [lg_els_lp-1:0] r_wptr;
  logic [lg_els_lp:0]   r_count;
  logic [counter_width_p-1:0] r_dual_count;

  logic [lg_els_lp-1:0] w_rptr_p1;
  logic [lg_els_lp-1:0] w_wptr_p1;
  logic [lg_els_lp:0]   w_free;
  logic [1:0]           w_n_enq;
  logic [1:0]           w_n_deq;
  logic                 w_enq_fire;
  logic                 w_deq_fire;
  logic [31:0]          w_a;
  logic [31:0]          w_b;
  decode_s              w_dec_a;
  decode_s              w_dec_b;
  fp_decode_s           w_fpd_a;
  fp_decode_s           w_fpd_b;
  logic                 w_b_v;
  logic                 w_two_int, w_two_fp, w_ctrl;
  logic                 w_raw, w_raw_f, w_war, w_war_f, w_waw;
  logic                 w_pairable;

  assign w_rptr_p1 = r_rptr + lg_els_lp'(1);
  assign w_wptr_p1 = r_wptr + lg_els_lp'(1);
  assign w_free    = (lg_els_lp+1)'(els_p) - r_count;

  // Readiness looks only at the current occupancy, ignoring any dequeue in
  // the same cycle, so it never depends on issue_yumi_i.
  assign enq_ready_o = (w_free >= (lg_els_lp+1)'(2));
  assign w_n_enq     = (enq_count_i == 2'd3) ? 2'd0 : enq_count_i;
  assign w_enq_fire  = enq_ready_o & (w_n_enq != 2'd0) & ~flush_i;

  // Head pair
  assign w_a     = r_mem[r_rptr];
  assign w_b     = r_mem[w_rptr_p1];
  assign w_dec_a = cl_decode(w_a);
  assign w_dec_b = cl_decode(w_b);
  assign w_fpd_a = cl_fp_decode(w_a);
  assign w_fpd_b = cl_fp_decode(w_b);
  assign w_b_v   = (r_count >= (lg_els_lp+1)'(2));

  // Register fields: rd [11:7], rs1 [19:15], rs2 [24:20], rs3 [31:27]
  assign w_two_int = ~w_dec_a.is_fp_op & ~w_dec_b.is_fp_op;
  assign w_two_fp  =  w_dec_a.is_fp_op &  w_dec_b.is_fp_op;
  assign w_ctrl    = w_dec_a.is_branch | w_dec_a.is_jal | w_dec_a.is_jalr;

  assign w_raw =
      (w_dec_a.write_rd_f & w_dec_b.read_rs1   & (w_a[11:7] == w_b[19:15]))
    | (w_dec_a.write_rd_f & w_dec_b.read_rs2   & (w_a[11:7] == w_b[24:20]))
    | (w_dec_a.write_rd   & w_dec_b.read_rs1_f & (w_a[11:7] == w_b[19:15]));

  assign w_raw_f =
      (w_dec_a.write_frd   & w_dec_b.read_frs2_s & (w_a[11:7] == w_b[24:20]))
    | (w_dec_a.write_frd_l & w_dec_b.read_frs1   & (w_a[11:7] == w_b[19:15]))
    | (w_dec_a.write_frd_l & w_dec_b.read_frs2   & (w_a[11:7] == w_b[24:20]))
    | (w_dec_a.write_frd_l & w_dec_b.read_frs3   & (w_a[11:7] == w_b[31:27]));

  assign w_war =
      (w_dec_a.read_rs1_f & w_dec_b.write_rd   & (w_a[19:15] == w_b[11:7]))
    | (w_dec_a.read_rs1   & w_dec_b.write_rd_f & (w_a[19:15] == w_b[11:7]))
    | (w_dec_a.read_rs2   & w_dec_b.write_rd_f & (w_a[24:20] == w_b[11:7]));

  assign w_war_f =
      (w_dec_b.write_frd_l & w_dec_a.read_frs1   & (w_a[19:15] == w_b[11:7]))
    | (w_dec_b.write_frd_l & w_dec_a.read_frs2   & (w_a[24:20] == w_b[11:7]))
    | (w_dec_b.write_frd_l & w_dec_a.read_frs3   & (w_a[31:27] == w_b[11:7]))
    | (w_dec_a.read_frs2_s & w_dec_b.write_frd   & (w_a[24:20] == w_b[11:7]));

  assign w_waw = (w_a[11:7] == w_b[11:7]) & (
      ((w_dec_a.write_frd | w_dec_a.write_frd_l) & (w_dec_b.write_frd | w_dec_b.write_frd_l))
    | ((w_dec_a.write_rd  | w_dec_a.write_rd_f)  & (w_dec_b.write_rd  | w_dec_b.write_rd_f)));

  assign w_pairable = w_b_v & dual_en_i &
                      ~(w_two_int | w_two_fp | w_ctrl | w_raw | w_raw_f | w_war | w_war_f | w_waw);

  assign issue_v_o    = (r_count != '0);
  assign issue_dual_o = issue_v_o & w_pairable;

  always_comb begin
    issue_instr_o     = '0;
    issue_instr_f_o   = '0;
    issue_decode_o    = '0;
    issue_fp_decode_o = '0;
    if (issue_dual_o) begin
      issue_decode_o = w_dec_a | w_dec_b;
      if (w_dec_a.is_fp_op) begin
        issue_instr_o     = w_b;
        issue_instr_f_o   = w_a;
        issue_fp_decode_o = w_fpd_a;
      end else begin
        issue_instr_o     = w_a;
        issue_instr_f_o   = w_b;
        issue_fp_decode_o = w_fpd_b;
      end
    end else if (issue_v_o) begin
      issue_instr_o     = w_a;
      issue_instr_f_o   = w_a;
      issue_decode_o    = w_dec_a;
      issue_fp_decode_o = w_fpd_a;
    end
  end

  assign w_deq_fire = issue_yumi_i & issue_v_o & ~flush_i;
  assign w_n_deq    = w_deq_fire ? (issue_dual_o ? 2'd2 : 2'd1) : 2'd0;

  // Storage is not reset; entries become visible only through r_count.
  always_ff @(posedge clk_i) begin
    if (w_enq_fire) begin
      r_mem[r_wptr] <= enq_instr_i[0];
      if (w_n_enq == 2'd2) r_mem[w_wptr_p1] <= enq_instr_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + lg_els_lp'(w_n_deq);
      r_wptr  <= r_wptr + (w_enq_fire ? lg_els_lp'(w_n_enq) : lg_els_lp'(0));
      r_count <= r_count + (w_enq_fire ? (lg_els_lp+1)'(w_n_enq) : (lg_els_lp+1)'(0))
                         - (lg_els_lp+1)'(w_n_deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dual_count <= '0;
    end else if (w_deq_fire & issue_dual_o & (r_dual_count != '1)) begin
      r_dual_count <= r_dual_count + counter_width_p'(1);
    end
  end

  assign dual_count_o = r_dual_count;

endmodule

// File: tb/tb_dual_issue_queue.sv
module tb_dual_issue_queue;
  import dual_issue_queue_pkg::*;

  // Model entry: instruction plus the register sets it reads and writes.
  typedef struct packed {
    logic [31:0] instr;
    logic        is_fp;
    logic        ctrl;
    logic [31:0] ir;
    logic [31:0] iw;
    logic [31:0] fr;
    logic [31:0] fw;
  } ent_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            den;
  logic [1:0]      enq_n;
  logic [1:0][31:0] enq_instr;
  logic            enq_ready;
  logic            issue_v;
  logic            issue_dual;
  logic [31:0]     issue_instr;
  logic [31:0]     issue_instr_f;
  decode_s         issue_dec;
  fp_decode_s      issue_fpdec;
  logic            yumi;
  logic [31:0]     dual_count;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t cur_e0, cur_e1;
  ent_t mq[$];
  logic [31:0] mdual;

  dual_issue_queue dut (
    .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .dual_en_i(den),
    .enq_count_i(enq_n), .enq_instr_i(enq_instr), .enq_ready_o(enq_ready),
    .issue_v_o(issue_v), .issue_dual_o(issue_dual), .issue_instr_o(issue_instr),
    .issue_instr_f_o(issue_instr_f), .issue_decode_o(issue_dec),
    .issue_fp_decode_o(issue_fpdec), .issue_yumi_i(yumi), .dual_count_o(dual_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Kinds: 0 add 1 addi 2 lw 3 sw 4 beq 5 jal 6 flw 7 fsw 8 fadd.s
  //        9 fmv.x.w 10 fcvt.s.w 11 fmadd.s 12 jalr
  function automatic ent_t mk(input int k, input logic [4:0] rd, rs1, rs2, rs3);
    ent_t e;
    logic [31:0] d, s1, s2, s3;
    e = '0;
    d = 32'd1 << rd; s1 = 32'd1 << rs1; s2 = 32'd1 << rs2; s3 = 32'd1 << rs3;
    case (k)
      0:  begin e.instr = {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011}; e.ir = s1 | s2; e.iw = d; end
      1:  begin e.instr = {12'd1, rs1, 3'b000, rd, 7'b0010011}; e.ir = s1; e.iw = d; end
      2:  begin e.instr = {12'd0, rs1, 3'b010, rd, 7'b0000011}; e.ir = s1; e.iw = d; end
      3:  begin e.instr = {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011}; e.ir = s1 | s2; end
      4:  begin e.instr = {7'd0, rs2, rs1, 3'b000, 5'd8, 7'b1100011}; e.ir = s1 | s2; e.ctrl = 1'b1; end
      5:  begin e.instr = {20'h00800, rd, 7'b1101111}; e.iw = d; e.ctrl = 1'b1; end
      6:  begin e.instr = {12'd0, rs1, 3'b010, rd, 7'b0000111}; e.ir = s1; e.fw = d; end
      7:  begin e.instr = {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100111}; e.ir = s1; e.fr = s2; end
      8:  begin e.instr = {7'd0, rs2, rs1, 3'b000, rd, 7'b1010011}; e.is_fp = 1'b1; e.fr = s1 | s2; e.fw = d; end
      9:  begin e.instr = {7'b1110000, 5'd0, rs1, 3'b000, rd, 7'b1010011}; e.is_fp = 1'b1; e.fr = s1; e.iw = d; end
      10: begin e.instr = {7'b1101000, 5'd0, rs1, 3'b000, rd, 7'b1010011}; e.is_fp = 1'b1; e.ir = s1; e.fw = d; end
      11: begin e.instr = {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1000011}; e.is_fp = 1'b1; e.fr = s1 | s2 | s3; e.fw = d; end
      default: begin e.instr = {12'd0, rs1, 3'b000, rd, 7'b1100111}; e.ir = s1; e.iw = d; e.ctrl = 1'b1; end
    endcase
    return e;
  endfunction

  // Pair only one int op with one FP op, never after control flow, and never
  // when the two touch a common register with at least one of them writing it.
  function automatic bit pairable(input ent_t a, input ent_t b);
    logic [31:0] clash;
    clash = (a.iw & b.ir) | (b.iw & a.ir) | (a.iw & b.iw)
          | (a.fw & b.fr) | (b.fw & a.fr) | (a.fw & b.fw);
    return (a.is_fp != b.is_fp) && !a.ctrl && (clash == 32'd0);
  endfunction

  // Compare process: check against the model, then advance it by one edge.
  always @(negedge clk) begin
    bit ev, pr, rdy;
    ent_t a, b;
    logic [31:0] e_i, e_f;
    if (!rst_n) begin
      chk("rst_issue_v", {31'd0, issue_v}, 32'd0);
      chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
      chk("rst_dual_count", dual_count, 32'd0);
      mq.delete();
      mdual = 32'd0;
    end else begin
      ev  = mq.size() > 0;
      rdy = (8 - mq.size()) >= 2;
      a = '0; b = '0;
      if (ev) a = mq[0];
      if (mq.size() >= 2) b = mq[1];
      pr = (mq.size() >= 2) && den && pairable(a, b);
      e_i = a.instr; e_f = a.instr;
      if (pr) begin
        e_i = a.is_fp ? b.instr : a.instr;
        e_f = a.is_fp ? a.instr : b.instr;
      end
      chk("issue_v", {31'd0, issue_v}, {31'd0, ev});
      chk("issue_dual", {31'd0, issue_dual}, {31'd0, pr});
      chk("issue_instr", issue_instr, e_i);
      chk("issue_instr_f", issue_instr_f, e_f);
      chk("dec_is_fp", {31'd0, issue_dec.is_fp_op}, {31'd0, ev && (pr || a.is_fp)});
      chk("enq_ready", {31'd0, enq_ready}, {31'd0, rdy});
      chk("dual_count", dual_count, mdual);
      if (flush) begin
        mq.delete();
      end else begin
        if (yumi && ev) begin
          void'(mq.pop_front());
          if (pr) begin
            void'(mq.pop_front());
            if (mdual != 32'hFFFF_FFFF) mdual++;
          end
        end
        if (rdy && enq_n != 2'd0) begin
          mq.push_back(cur_e0);
          if (enq_n == 2'd2) mq.push_back(cur_e1);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] n, input ent_t e0, input ent_t e1,
                       input logic y, input logic fl, input logic de);
    @(posedge clk);
    #1;
    cur_e0 = e0; cur_e1 = e1;
    enq_n = n; enq_instr[0] = e0.instr; enq_instr[1] = e1.instr;
    yumi = y; flush = fl; den = de;
  endtask

  task automatic drain;
    for (int k = 0; k < 20; k++) begin
      if (!issue_v) break;
      drive(2'd0, '0, '0, 1'b1, 1'b0, 1'b1);
      #2;
    end
    chk("drain_empty", {31'd0, issue_v}, 32'd0);
  endtask

  initial begin
    ent_t add_e, fadd_e, flw_e, fadd2_e, beq_e, z;
    z = '0;
    rst_n = 1'b0; flush = 1'b0; den = 1'b1; enq_n = 2'd0; yumi = 1'b0;
    enq_instr = '0; cur_e0 = '0; cur_e1 = '0; mdual = 32'd0;
    add_e   = mk(0, 5'd5, 5'd1, 5'd2, 5'd0);
    fadd_e  = mk(8, 5'd3, 5'd1, 5'd2, 5'd0);
    flw_e   = mk(6, 5'd1, 5'd4, 5'd0, 5'd0);
    fadd2_e = mk(8, 5'd2, 5'd1, 5'd3, 5'd0);
    beq_e   = mk(4, 5'd0, 5'd1, 5'd2, 5'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #3;
    chk("idle_v", {31'd0, issue_v}, 32'd0);
    chk("idle_ready", {31'd0, enq_ready}, 32'd1);
    chk("idle_dual_count", dual_count, 32'd0);

    // add x5,x1,x2 ; fadd.s f3,f1,f2 -> one dual bundle
    drive(2'd2, add_e, fadd_e, 1'b1, 1'b0, 1'b1);
    drive(2'd0, z, z, 1'b1, 1'b0, 1'b1); #2;
    chk("pair_dual", {31'd0, issue_dual}, 32'd1);
    chk("pair_int", issue_instr, 32'h002082B3);
    chk("pair_fp", issue_instr_f, 32'h002081D3);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b1); #2;
    chk("pair_empty", {31'd0, issue_v}, 32'd0);
    chk("pair_count", dual_count, 32'd1);

    // flw f1 ; fadd.s f2,f1,f3 -> RAW on f1, two singles
    drive(2'd2, flw_e, fadd2_e, 1'b0, 1'b0, 1'b1);
    drive(2'd0, z, z, 1'b1, 1'b0, 1'b1); #2;
    chk("rawf_single0", {31'd0, issue_dual}, 32'd0);
    chk("rawf_instr0", issue_instr, 32'h00022087);
    drive(2'd0, z, z, 1'b1, 1'b0, 1'b1); #2;
    chk("rawf_instr1", issue_instr_f, 32'h00308153);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b1); #2;
    chk("rawf_count", dual_count, 32'd1);

    // beq ; fadd -> branch at head blocks pairing
    drive(2'd2, beq_e, fadd_e, 1'b0, 1'b0, 1'b1);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b1); #2;
    chk("beq_single", {31'd0, issue_dual}, 32'd0);
    chk("beq_instr", issue_instr, 32'h00208463);
    drain();

    // Fill across the wrap point, drop the fifth pair, then drain in order
    for (int p = 0; p < 4; p++)
      drive(2'd2, mk(0, 5'(p + 8), 5'd1, 5'd2, 5'd0), mk(8, 5'(p + 8), 5'd1, 5'd2, 5'd0),
            1'b0, 1'b0, 1'b1);
    drive(2'd2, mk(1, 5'd20, 5'd1, 5'd0, 5'd0), mk(8, 5'd21, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0, 1'b1);
    #2 chk("full_ready", {31'd0, enq_ready}, 32'd0);
    drive(2'd0, z, z, 1'b1, 1'b0, 1'b0);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b1); #2;
    chk("ready_at_7", {31'd0, enq_ready}, 32'd0);
    drain();

    // Runtime dual-issue enable on a pairable head
    drive(2'd2, add_e, fadd_e, 1'b0, 1'b0, 1'b0);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b0); #2;
    chk("den0_single", {31'd0, issue_dual}, 32'd0);
    den = 1'b1; #1;
    chk("den1_dual", {31'd0, issue_dual}, 32'd1);
    drain();

    // Flush with five entries, overriding a same-cycle enqueue and yumi
    drive(2'd2, add_e, fadd_e, 1'b0, 1'b0, 1'b0);
    drive(2'd2, add_e, fadd_e, 1'b0, 1'b0, 1'b0);
    drive(2'd1, beq_e, z, 1'b0, 1'b0, 1'b0);
    drive(2'd2, add_e, fadd_e, 1'b1, 1'b1, 1'b0);
    drive(2'd0, z, z, 1'b0, 1'b0, 1'b1); #2;
    chk("flush_v", {31'd0, issue_v}, 32'd0);
    chk("flush_ready", {31'd0, enq_ready}, 32'd1);

    // Randomized traffic, with small register numbers to provoke hazards
    for (int c = 0; c < 2500; c++) begin
      logic fl, y;
      fl = ($urandom % 40) == 0;
      y  = fl ? 1'b0 : (($urandom % 10) < 6);
      drive(2'($urandom % 3),
            mk(int'($urandom % 13), 5'($urandom % 6), 5'($urandom % 6), 5'($urandom % 6), 5'($urandom % 6)),
            mk(int'($urandom % 13), 5'($urandom % 6), 5'($urandom % 6), 5'($urandom % 6), 5'($urandom % 6)),
            y, fl, (($urandom % 100) < 85));
    end

    // Asynchronous reset in the middle of draining
    drive(2'd2, add_e, fadd_e, 1'b0, 1'b0, 1'b1);
    drive(2'd2, flw_e, fadd2_e, 1'b0, 1'b0, 1'b1);
    drive(2'd0, z, z, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("areset_v", {31'd0, issue_v}, 32'd0);
    chk("areset_count", dual_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) drive(2'd0, z, z, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
